// File: rtl/l2_memory_responder.sv
// Memory-side responder for the L1-to-L2 request interface: one word LOAD/STORE
// at a time, serviced from a word-addressed backing store after a fixed latency.

package torrence_types;
    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01
    } memory_operation_e;
endpackage

module l2_memory_responder
    import torrence_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 1024,
    parameter int LATENCY  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   req_address,
    input  memory_operation_e req_type,
    input  logic              req_valid,
    input  logic [XLEN-1:0]   req_store_word,
    output logic [XLEN-1:0]   fetched_word,
    output logic              req_fulfilled,
    output logic              busy
);

    localparam int OFFSET_W = $clog2(XLEN / 8);
    localparam int ADDR_W   = $clog2(MEM_SIZE);
    localparam int IDX_W    = (ADDR_W > OFFSET_W) ? (ADDR_W - OFFSET_W) : 1;
    localparam int WORDS    = 1 << IDX_W;
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_RESPOND = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    memory_operation_e type_q, type_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [XLEN-1:0]   fetched_q, fetched_d;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  svc_idx;
    memory_operation_e svc_type;
    logic [XLEN-1:0]   svc_data;
    logic              enter_respond;
    logic              mem_we;

    logic [XLEN-1:0]   mem_q [WORDS] = '{default: '0};

    // Byte offset dropped, upper bits truncated: accesses wrap modulo MEM_SIZE.
    assign req_idx = IDX_W'(req_address >> OFFSET_W);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        type_d        = type_q;
        data_d        = data_q;
        enter_respond = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d  = req_idx;
                    type_d = req_type;
                    data_d = req_store_word;
                    if (LATENCY == 1) begin
                        state_d       = ST_RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d       = ST_RESPOND;
                    enter_respond = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge, before the
    // request fields have been latched, so service straight from the inputs.
    always_comb begin
        svc_idx  = idx_q;
        svc_type = type_q;
        svc_data = data_q;
        if (state_q == ST_IDLE) begin
            svc_idx  = req_idx;
            svc_type = req_type;
            svc_data = req_store_word;
        end
    end

    always_comb begin
        fetched_d = fetched_q;
        mem_we    = 1'b0;
        if (enter_respond) begin
            case (svc_type)
                LOAD:    fetched_d = mem_q[svc_idx];
                STORE: begin
                    fetched_d = svc_data;
                    mem_we    = reset;
                end
                default: fetched_d = fetched_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            type_q    <= LOAD;
            data_q    <= '0;
            fetched_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            type_q    <= type_d;
            data_q    <= data_d;
            fetched_q <= fetched_d;
        end
    end

    // Backing store survives reset; the write enable is already gated by it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[svc_idx] <= svc_data;
        end
    end

    assign fetched_word  = fetched_q;
    assign req_fulfilled = (state_q == ST_RESPOND);
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_l2_memory_responder.sv
// Bench for l2_memory_responder: one LATENCY=4 and one LATENCY=1 instance,
// checked every cycle against a transaction-level memory model.

module tb_l2_memory_responder;
    import torrence_types::*;

    logic              clk;
    logic              reset;
    logic [31:0]       req_address    [2];
    memory_operation_e req_type       [2];
    logic              req_valid      [2];
    logic [31:0]       req_store_word [2];
    logic [31:0]       fetched_word   [2];
    logic              req_fulfilled  [2];
    logic              busy           [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Pulse appears LATENCY edges after acceptance, or on the acceptance edge itself when LATENCY=1.
    int                pulse_delay [2] = '{4, 0};
    logic              m_pend    [2];
    int                m_acc     [2];
    memory_operation_e m_type    [2];
    logic [31:0]       m_addr    [2];
    logic [31:0]       m_data    [2];
    logic [31:0]       m_fetched [2];
    logic [31:0]       m_mem     [2][256];
    logic              exp_ful;
    logic              exp_busy;

    l2_memory_responder #(.XLEN(32), .MEM_SIZE(1024), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_address(req_address[0]), .req_type(req_type[0]),
        .req_valid(req_valid[0]), .req_store_word(req_store_word[0]),
        .fetched_word(fetched_word[0]), .req_fulfilled(req_fulfilled[0]),
        .busy(busy[0])
    );

    l2_memory_responder #(.XLEN(32), .MEM_SIZE(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_address(req_address[1]), .req_type(req_type[1]),
        .req_valid(req_valid[1]), .req_store_word(req_store_word[1]),
        .fetched_word(fetched_word[1]), .req_fulfilled(req_fulfilled[1]),
        .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int word_of(input logic [31:0] a);
        return int'((a % 32'd1024) / 32'd4);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d]    = 1'b0;
            m_fetched[d] = 32'h0;
        end
    endtask

    // Model state advances in the cycle the response is due, then every output is compared.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_busy = m_pend[d];
            exp_ful  = 1'b0;
            if (m_pend[d] && cyc == m_acc[d] + pulse_delay[d]) begin
                exp_ful = 1'b1;
                if (m_type[d] == LOAD) begin
                    m_fetched[d] = m_mem[d][word_of(m_addr[d])];
                end else if (m_type[d] == STORE) begin
                    m_mem[d][word_of(m_addr[d])] = m_data[d];
                    m_fetched[d] = m_data[d];
                end
            end
            checkOutput($sformatf("dut%0d busy @%0d", d, cyc), 32'(busy[d]), 32'(exp_busy));
            checkOutput($sformatf("dut%0d req_fulfilled @%0d", d, cyc), 32'(req_fulfilled[d]), 32'(exp_ful));
            checkOutput($sformatf("dut%0d fetched_word @%0d", d, cyc), fetched_word[d], m_fetched[d]);
            if (exp_ful) m_pend[d] = 1'b0;
        end
    end

    // Presents one request, records it in the model at acceptance, and returns
    // at the start of the IDLE cycle following the pulse.
    task automatic applyStimulus(input int d, input memory_operation_e t, input logic [31:0] addr,
                                 input logic [31:0] data, output int acc, output int pulse);
        req_address[d]    = addr;
        req_type[d]       = t;
        req_store_word[d] = data;
        req_valid[d]      = 1'b1;
        @(posedge clk); #1;
        acc          = cyc;
        m_pend[d]    = 1'b1;
        m_acc[d]     = acc;
        m_type[d]    = t;
        m_addr[d]    = addr;
        m_data[d]    = data;
        req_valid[d]      = 1'b0;
        req_address[d]    = ~addr;
        req_store_word[d] = ~data;
        pulse = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_fulfilled[d]) begin
                pulse = cyc;
                break;
            end
        end
        checkOutput($sformatf("dut%0d pulse seen", d), 32'(pulse >= 0), 32'd1);
        @(posedge clk); #1;
    endtask

    int acc, pulse, first_acc, last_pulse;

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_address[d]    = 32'h0;
            req_type[d]       = LOAD;
            req_valid[d]      = 1'b0;
            req_store_word[d] = 32'h0;
            for (int w = 0; w < 256; w++) m_mem[d][w] = 32'h0;
        end
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("dut%0d reset fulfilled", d), 32'(req_fulfilled[d]), 32'd0);
            checkOutput($sformatf("dut%0d reset busy", d), 32'(busy[d]), 32'd0);
            checkOutput($sformatf("dut%0d reset fetched", d), fetched_word[d], 32'h0);
        end

        // Reset mid-WAIT during a STORE: pulse aborted, data discarded, fetched cleared.
        applyStimulus(0, STORE, 32'h200, 32'h12345678, acc, pulse);
        checkOutput("store fetched", fetched_word[0], 32'h12345678);
        req_address[0] = 32'h80; req_type[0] = STORE;
        req_store_word[0] = 32'h55555555; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        m_pend[0] = 1'b1; m_acc[0] = acc; m_type[0] = STORE;
        m_addr[0] = 32'h80; m_data[0] = 32'h55555555;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        #1;
        checkOutput("abort fulfilled", 32'(req_fulfilled[0]), 32'd0);
        checkOutput("abort busy", 32'(busy[0]), 32'd0);
        checkOutput("abort fetched", fetched_word[0], 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        applyStimulus(0, LOAD, 32'h40, 32'h0, acc, pulse);
        checkOutput("load 0x40 after reset", fetched_word[0], 32'h0);
        applyStimulus(0, LOAD, 32'h80, 32'h0, acc, pulse);
        checkOutput("discarded store 0x80", fetched_word[0], 32'h0);

        // Round trip with the four-cycle latency.
        applyStimulus(0, STORE, 32'h40, 32'hDEADBEEF, acc, pulse);
        checkOutput("store latency", 32'(pulse - acc), 32'd4);
        applyStimulus(0, LOAD, 32'h40, 32'h0, acc, pulse);
        checkOutput("load latency", 32'(pulse - acc), 32'd4);
        checkOutput("round trip data", fetched_word[0], 32'hDEADBEEF);

        // Address wrap and byte-offset alignment.
        applyStimulus(0, STORE, 32'h0, 32'h11111111, acc, pulse);
        applyStimulus(0, LOAD, 32'h400, 32'h0, acc, pulse);
        checkOutput("wrap 0x400", fetched_word[0], 32'h11111111);
        applyStimulus(0, STORE, 32'h40, 32'h22222222, acc, pulse);
        applyStimulus(0, LOAD, 32'h43, 32'h0, acc, pulse);
        checkOutput("align 0x43", fetched_word[0], 32'h22222222);

        // Line fill: eight back-to-back loads at the minimum request period.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, STORE, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), acc, pulse);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, LOAD, 32'h100 + 32'(4 * i), 32'h0, acc, pulse);
            if (i == 0) first_acc = acc;
            last_pulse = pulse;
            checkOutput($sformatf("line fill word %0d", i), fetched_word[0], 32'hA0 + 32'(i));
        end
        checkOutput("line fill cycles", 32'(last_pulse - first_acc + 2), 32'd48);

        // LATENCY=1 instance, including an unrecognised operation type.
        applyStimulus(1, STORE, 32'h10, 32'h0BADF00D, acc, pulse);
        checkOutput("lat1 store latency", 32'(pulse - acc), 32'd0);
        applyStimulus(1, memory_operation_e'(2'b11), 32'h10, 32'hFFFFFFFF, acc, pulse);
        checkOutput("lat1 unknown latency", 32'(pulse - acc), 32'd0);
        checkOutput("lat1 unknown holds fetched", fetched_word[1], 32'h0BADF00D);
        applyStimulus(1, LOAD, 32'h10, 32'h0, acc, pulse);
        checkOutput("lat1 memory unchanged", fetched_word[1], 32'h0BADF00D);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
